// File: rtl/rcc_pkg.sv
// Shared state encoding, tone-bin indices and digit lookup for the DTMF
// result-character conversion stage.
package rcc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCUM     = 2'd1,
        ST_EVAL      = 2'd2,
        ST_CHARACTER = 2'd3
    } rcc_state_e;

    // Bins 0-3 are the row tones, 4-7 the column tones.
    localparam logic [2:0] BIN_ROW_697  = 3'd0;
    localparam logic [2:0] BIN_ROW_770  = 3'd1;
    localparam logic [2:0] BIN_ROW_852  = 3'd2;
    localparam logic [2:0] BIN_ROW_941  = 3'd3;
    localparam logic [2:0] BIN_COL_1209 = 3'd4;
    localparam logic [2:0] BIN_COL_1336 = 3'd5;
    localparam logic [2:0] BIN_COL_1477 = 3'd6;
    localparam logic [2:0] BIN_COL_1633 = 3'd7;

    localparam logic [7:0] SEEN_ALL = 8'hFF;

    // Indexed by {row, column}.
    localparam logic [7:0] DIGIT_LUT [16] = '{
        8'h31, 8'h32, 8'h33, 8'h41,
        8'h34, 8'h35, 8'h36, 8'h42,
        8'h37, 8'h38, 8'h39, 8'h43,
        8'h2A, 8'h30, 8'h23, 8'h44
    };

    function automatic logic [7:0] rcc_digit_ascii(input logic [1:0] row, input logic [1:0] col);
        return DIGIT_LUT[{row, col}];
    endfunction

endpackage

// File: rtl/rcc_group_max.sv
// Tracks maximum, index of maximum and second-highest magnitude over one group of 4 bins.
// Latency: registered, result visible the cycle after the update strobe.
// Backpressure: none; caller filters repeated bins and qualifies with upd_i.
module rcc_group_max #(
    parameter int unsigned MAG_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             upd_i,
    input  logic [1:0]       idx_i,
    input  logic [MAG_W-1:0] mag_i,
    output logic [MAG_W-1:0] max_o,
    output logic [1:0]       max_idx_o,
    output logic [MAG_W-1:0] second_o
);

    logic             any_q,     any_d;
    logic [MAG_W-1:0] max_q,     max_d;
    logic [1:0]       max_idx_q, max_idx_d;
    logic [MAG_W-1:0] sec_q,     sec_d;

    always_comb begin
        any_d     = any_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        sec_d     = sec_q;
        if (clr_i) begin
            any_d     = 1'b0;
            max_d     = '0;
            max_idx_d = '0;
            sec_d     = '0;
        end else if (upd_i) begin
            any_d = 1'b1;
            if (!any_q) begin
                max_d     = mag_i;
                max_idx_d = idx_i;
            end else if (mag_i > max_q) begin
                sec_d     = max_q;
                max_d     = mag_i;
                max_idx_d = idx_i;
            end else if (mag_i == max_q) begin
                // A tie leaves the max value intact but always fills second.
                sec_d = mag_i;
                if (idx_i < max_idx_q) begin
                    max_idx_d = idx_i;
                end
            end else if (mag_i > sec_q) begin
                sec_d = mag_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            any_q     <= 1'b0;
            max_q     <= '0;
            max_idx_q <= '0;
            sec_q     <= '0;
        end else begin
            any_q     <= any_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            sec_q     <= sec_d;
        end
    end

    assign max_o     = max_q;
    assign max_idx_o = max_idx_q;
    assign second_o  = sec_q;

endmodule

// File: rtl/rcc_digit_fsm.sv
// DTMF decision stage: picks dominant row/column tone per frame, validates, debounces, emits ASCII.
// Latency: char_load two cycles after the frame_end cycle (EVAL, then CHARACTER).
// Backpressure: none; frame_start/bin_valid outside their states are ignored. Optional RCC_TWIST_CHECK_EN.
module rcc_digit_fsm
    import rcc_pkg::*;
#(
    parameter int unsigned      MAG_W    = 16,
    parameter logic [MAG_W-1:0] THRESH   = 'h0400,
    parameter int unsigned      DEBOUNCE = 2
) (
    input  logic             rcc_clk,
    input  logic             rcc_rst_n,
    input  logic             frame_start,
    input  logic             bin_valid,
    input  logic [2:0]       bin_idx,
    input  logic [MAG_W-1:0] bin_mag,
    input  logic             frame_end,
    output logic [7:0]       char_out,
    output logic             char_load,
    output logic             busy
);

    localparam logic [2:0] DEB_C = 3'(DEBOUNCE);

    rcc_state_e state_q, state_d;

    logic [7:0] seen_q,     seen_d;
    logic [3:0] cand_q,     cand_d;
    logic       cand_vld_q, cand_vld_d;
    logic [2:0] cnt_q,      cnt_d;
    logic       emitted_q,  emitted_d;
    logic [7:0] char_out_q, char_out_d;

    logic       acc_clr;
    logic       acc_upd;
    logic       row_upd;
    logic       col_upd;
    logic [7:0] bin_onehot;
    logic       emit_due;

    logic [MAG_W-1:0] row_max, row_sec, col_max, col_sec;
    logic [1:0]       row_idx, col_idx;
    logic [3:0]       digit_code;
    logic             row_dom, col_dom, thresh_ok, twist_ok, frame_ok;

    assign bin_onehot = 8'b1 << bin_idx;
    assign row_upd    = acc_upd && (bin_idx <  BIN_COL_1209);
    assign col_upd    = acc_upd && (bin_idx >= BIN_COL_1209);

    rcc_group_max #(.MAG_W(MAG_W)) u_row_max (
        .clk_i     (rcc_clk),
        .rst_n_i   (rcc_rst_n),
        .clr_i     (acc_clr),
        .upd_i     (row_upd),
        .idx_i     (bin_idx[1:0]),
        .mag_i     (bin_mag),
        .max_o     (row_max),
        .max_idx_o (row_idx),
        .second_o  (row_sec)
    );

    rcc_group_max #(.MAG_W(MAG_W)) u_col_max (
        .clk_i     (rcc_clk),
        .rst_n_i   (rcc_rst_n),
        .clr_i     (acc_clr),
        .upd_i     (col_upd),
        .idx_i     (bin_idx[1:0]),
        .mag_i     (bin_mag),
        .max_o     (col_max),
        .max_idx_o (col_idx),
        .second_o  (col_sec)
    );

    // Dominance is max >= 2*second, widened by one bit so the doubling cannot wrap.
    assign row_dom    = {1'b0, row_max} >= {row_sec, 1'b0};
    assign col_dom    = {1'b0, col_max} >= {col_sec, 1'b0};
    assign thresh_ok  = (row_max >= THRESH) && (col_max >= THRESH);
    assign digit_code = {row_idx, col_idx};

`ifdef RCC_TWIST_CHECK_EN
    assign twist_ok = ({2'b00, row_max} <= {col_max, 2'b00}) &&
                      ({2'b00, col_max} <= {row_max, 2'b00});
`else
    assign twist_ok = 1'b1;
`endif

    assign frame_ok = (seen_q == SEEN_ALL) && thresh_ok && row_dom && col_dom && twist_ok;

    // Debounce bookkeeping only moves in EVAL, once per closed frame.
    always_comb begin
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        cnt_d      = cnt_q;
        emitted_d  = emitted_q;
        char_out_d = char_out_q;
        emit_due   = 1'b0;
        if (state_q == ST_EVAL) begin
            if (frame_ok) begin
                if (cand_vld_q && (cand_q == digit_code)) begin
                    if (cnt_q < DEB_C) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    cand_d     = digit_code;
                    cand_vld_d = 1'b1;
                    cnt_d      = 3'd1;
                    emitted_d  = 1'b0;
                end
                if ((cnt_d == DEB_C) && !emitted_d) begin
                    emit_due   = 1'b1;
                    emitted_d  = 1'b1;
                    char_out_d = rcc_digit_ascii(row_idx, col_idx);
                end
            end else begin
                cand_d     = '0;
                cand_vld_d = 1'b0;
                cnt_d      = '0;
                emitted_d  = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_clr   = 1'b0;
        acc_upd   = 1'b0;
        seen_d    = seen_q;
        char_load = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    acc_clr = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // A fresh frame_start outranks both bins and frame_end in the same cycle.
                if (frame_start) begin
                    acc_clr = 1'b1;
                end else begin
                    if (bin_valid) begin
                        acc_upd = !seen_q[bin_idx];
                        seen_d  = seen_q | bin_onehot;
                    end
                    if (frame_end) begin
                        state_d = ST_EVAL;
                    end
                end
            end
            ST_EVAL: begin
                state_d = emit_due ? ST_CHARACTER : ST_IDLE;
            end
            ST_CHARACTER: begin
                char_load = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (acc_clr) begin
            seen_d = '0;
        end
    end

    always_ff @(posedge rcc_clk or negedge rcc_rst_n) begin
        if (!rcc_rst_n) begin
            state_q    <= ST_IDLE;
            seen_q     <= '0;
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
            cnt_q      <= '0;
            emitted_q  <= 1'b0;
            char_out_q <= '0;
        end else begin
            state_q    <= state_d;
            seen_q     <= seen_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            cnt_q      <= cnt_d;
            emitted_q  <= emitted_d;
            char_out_q <= char_out_d;
        end
    end

    assign char_out = char_out_q;

endmodule
